reg_port_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one RAM-like register port (address/en/we/wdata, 1-cycle read data)

---
 rtl/reg_port_rr_arbiter.sv | 113 +++++++++++
 tb/tb_reg_port_rr_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_port_rr_arbiter.sv
// Round-robin arbiter sharing one RAM-like register port between NumReq requesters.
// Combinational grant and port drive, one registered response stage (1-cycle read data / write ack).
module reg_port_rr_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic [AddrWidth-1:0]          address_o,
    output logic                          en_o,
    output logic                          we_o,
    output logic [DataWidth-1:0]          data_o,
    input  logic [DataWidth-1:0]          data_i
);

    localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 1);

    logic [NumReq-1:0]    req_act;
    logic [AddrWidth-1:0] addr_arr  [NumReq];
    logic [DataWidth-1:0] wdata_arr [NumReq];
    logic [IdxWidth-1:0]  rr_ptr_q;
    logic [IdxWidth-1:0]  rr_ptr_d;
    logic [IdxWidth-1:0]  win;
    logic                 found;
    int unsigned          cand;
    logic                 rsp_valid_q;
    logic                 rsp_we_q;
    logic [IdxWidth-1:0]  rsp_idx_q;

    // Requests are masked while in reset so nothing reaches the port
    assign req_act = rst_ni ? req_i : '0;

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign addr_arr[g]  = addr_i[g*AddrWidth +: AddrWidth];
        assign wdata_arr[g] = wdata_i[g*DataWidth +: DataWidth];
    end

    // First requester at or after the pointer, wrapping, wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!found && req_act[IdxWidth'(cand)]) begin
                found = 1'b1;
                win   = IdxWidth'(cand);
            end
        end
    end

    // Only the winner's lane is muxed onto the port
    always_comb begin
        gnt_o     = '0;
        en_o      = 1'b0;
        we_o      = 1'b0;
        address_o = '0;
        data_o    = '0;
        if (found) begin
            gnt_o[win] = 1'b1;
            en_o       = 1'b1;
            we_o       = we_i[win];
            address_o  = addr_arr[win];
            data_o     = wdata_arr[win];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (win == LastIdx) ? '0 : IdxWidth'(win + IdxWidth'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_we_q    <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= found;
            rsp_idx_q   <= win;
            rsp_we_q    <= found & we_i[win];
        end
    end

    // Response targets the previous cycle's winner; read data only for reads
    always_comb begin
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        if (rst_ni && rsp_valid_q) begin
            rsp_valid_o[rsp_idx_q] = 1'b1;
            if (!rsp_we_q) begin
                rsp_rdata_o = data_i;
            end
        end
    end

endmodule

// File: tb/tb_reg_port_rr_arbiter.sv
// Bench for reg_port_rr_arbiter (3 requesters so the pointer wrap is exercised).
// Driver pushes expected port/response values; a negedge monitor pops and compares.
module tb_reg_port_rr_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      req_i = '0;
    logic [N-1:0]      we_i = '0;
    logic [N*AW-1:0]   addr_i = '0;
    logic [N*DW-1:0]   wdata_i = '0;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      rsp_valid_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic [AW-1:0]     address_o;
    logic              en_o;
    logic              we_o;
    logic [DW-1:0]     data_o;
    logic [DW-1:0]     data_i = '0;

    reg_port_rr_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .address_o(address_o), .en_o(en_o), .we_o(we_o), .data_o(data_o), .data_i(data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  gnt;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } port_t;

    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] rdata;
    } rsp_t;

    port_t exp_port[$];
    rsp_t  exp_rsp[$];

    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            m_ptr = 0;
    int            m_win = -1;
    logic [DW-1:0] nd = '0;
    logic [AW-1:0] t_addr  [N];
    logic [DW-1:0] t_wdata [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus plus the reference model's prediction for it
    task automatic step(input logic rst, input logic [N-1:0] rq, input logic [N-1:0] wv,
                        input logic [DW-1:0] rd_next);
        port_t p;
        rsp_t  r;
        int    best_dist;
        @(posedge clk);
        #1;
        rst_ni = rst;
        req_i  = rq;
        we_i   = wv;
        for (int k = 0; k < N; k++) begin
            addr_i[k*AW +: AW]  = t_addr[k];
            wdata_i[k*DW +: DW] = t_wdata[k];
        end
        data_i = nd;
        nd     = rd_next;
        p      = '{gnt: '0, en: 1'b0, we: 1'b0, addr: '0, data: '0};
        m_win  = -1;
        if (!rst) begin
            m_ptr = 0;
            while (exp_rsp.size() > 0 && exp_rsp[$].due >= cyc) void'(exp_rsp.pop_back());
        end else if (rq != '0) begin
            best_dist = N;
            for (int k = 0; k < N; k++) begin
                if (rq[k] && ((k - m_ptr + N) % N) < best_dist) begin
                    best_dist = (k - m_ptr + N) % N;
                    m_win     = k;
                end
            end
            p.gnt[m_win] = 1'b1;
            p.en         = 1'b1;
            p.we         = wv[m_win];
            p.addr       = t_addr[m_win];
            p.data       = t_wdata[m_win];
            r.due        = cyc + 1;
            r.idx        = m_win;
            r.rdata      = wv[m_win] ? '0 : rd_next;
            exp_rsp.push_back(r);
            m_ptr = (m_win + 1) % N;
        end
        exp_port.push_back(p);
    endtask

    always @(negedge clk) begin
        port_t p;
        rsp_t  r;
        logic [N-1:0] oh;
        if (exp_port.size() > 0) begin
            p = exp_port.pop_front();
            chk("gnt_o", 64'(gnt_o), 64'(p.gnt));
            chk("en_o", 64'(en_o), 64'(p.en));
            chk("we_o", 64'(we_o), 64'(p.we));
            chk("address_o", address_o, p.addr);
            chk("data_o", data_o, p.data);
        end
        if (rsp_valid_o != '0) begin
            if (exp_rsp.size() == 0 || exp_rsp[0].due != cyc) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected at cycle %0d: got rsp_valid_o=%b expected none", cyc, rsp_valid_o);
            end else begin
                r  = exp_rsp.pop_front();
                oh = '0;
                oh[r.idx] = 1'b1;
                chk("rsp_valid_o", 64'(rsp_valid_o), 64'(oh));
                chk("rsp_rdata_o", rsp_rdata_o, r.rdata);
            end
        end else begin
            if (exp_rsp.size() > 0 && exp_rsp[0].due <= cyc) begin
                r = exp_rsp.pop_front();
                checks++;
                errors++;
                $display("FAIL rsp_missing at cycle %0d: got rsp_valid_o=0 expected idx %0d", cyc, r.idx);
            end
            chk("rsp_rdata_idle", rsp_rdata_o, '0);
        end
    end

    initial begin
        logic [N-1:0] pend;
        logic [N-1:0] pwe;
        for (int k = 0; k < N; k++) begin
            t_addr[k]  = {$urandom, $urandom};
            t_wdata[k] = {$urandom, $urandom};
        end

        // reset held with every lane requesting
        repeat (3) step(1'b0, 3'b111, 3'b000, 64'h0);

        // single read from requester 0
        t_addr[0] = 64'h4000;
        step(1'b1, 3'b001, 3'b000, 64'hDEAD);

        // fairness after reset, then wrap from pointer 2 to requester 0
        step(1'b0, 3'b000, 3'b000, 64'h0);
        repeat (4) step(1'b1, 3'b011, 3'b000, {$urandom, $urandom});
        step(1'b1, 3'b011, 3'b000, 64'h1111);
        step(1'b1, 3'b010, 3'b000, 64'h2222);

        // write ack from requester 1
        t_addr[1]  = 64'h4008;
        t_wdata[1] = 64'h55;
        step(1'b1, 3'b010, 3'b010, 64'hBEEF);

        // reset mid-operation drops the pending response and rewinds the pointer
        step(1'b1, 3'b001, 3'b000, 64'h3333);
        @(negedge clk);
        #1;
        rst_ni = 1'b0;
        void'(exp_rsp.pop_back());
        m_ptr = 0;
        step(1'b1, 3'b011, 3'b000, 64'h4444);
        step(1'b1, 3'b010, 3'b000, 64'h5555);

        // random traffic, requests held until granted
        pend = '0;
        pwe  = '0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k]) begin
                    pend[k]    = 1'($urandom_range(1, 0));
                    pwe[k]     = 1'($urandom_range(1, 0));
                    t_addr[k]  = {$urandom, $urandom};
                    t_wdata[k] = {$urandom, $urandom};
                end
            end
            step(1'b1, pend, pwe, {$urandom, $urandom});
            if (m_win >= 0) pend[m_win] = 1'b0;
        end

        repeat (3) step(1'b1, 3'b000, 3'b000, 64'h0);
        @(posedge clk);
        #1;
        chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
